// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg : shared types and constants for the I2C target
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package i2c_pkg;

  localparam int         BYTE_W       = 8;
  localparam logic       I2C_ACK      = 1'b0;
  localparam logic       I2C_NACK     = 1'b1;
  localparam logic [6:0] DEFAULT_ADDR = 7'h50;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// ---------------------------------------------------------------------------
// i2c_sync_edge : multi-stage synchroniser with rise/fall pulse outputs
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle-bus level so no false edges appear after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

`default_nettype wire

// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave : oversampled I2C target with 7-bit address, write and read
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_req,
  output logic              busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .pin_in(scl_in),
    .level(scl_level), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .pin_in(sda_in),
    .level(sda_level), .rise(sda_rise), .fall(sda_fall)
  );

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;
  logic              start_cond, stop_cond;
  logic [BYTE_W-1:0] shift_in;

  assign start_cond = sda_fall & scl_level;
  assign stop_cond  = sda_rise & scl_level;
  assign shift_in   = {shift_q[BYTE_W-2:0], sda_level};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    tx_req     = 1'b0;

    if (start_cond) begin
      state_d  = ST_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_cond) begin
      state_d  = ST_IDLE;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (shift_in[7:1] == ADDR) begin
                busy_d  = 1'b1;
                rw_d    = shift_in[0];
                state_d = ST_ADDR_ACK;
                if (shift_in[0]) begin
                  tx_req  = 1'b1;
                  shift_d = tx_data;
                end
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        // cnt==8 marks the fall that opens the ACK slot; the 9th rise clears it
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_rise) begin
            cnt_d = 4'd0;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b1;
            end else if (state_q == ST_WR_ACK || !rw_q) begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_DATA;
            end else begin
              sda_oe_d = ~shift_q[BYTE_W-1];
              state_d  = ST_RD_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              state_d    = ST_WR_ACK;
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              sda_oe_d = ~shift_q[~cnt_q[2:0]];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_level == I2C_NACK) begin
              state_d = ST_IGNORE;
            end else begin
              tx_req  = 1'b1;
              shift_d = tx_data;
              cnt_d   = 4'd0;
              state_d = ST_RD_DATA;
            end
          end
        end
        ST_IGNORE: sda_oe_d = 1'b0;
        default:   state_d  = state_q;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave : self-checking bench driving an I2C master bus model
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_slave;

  localparam int QT = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  int         rx_pulses = 0, rx_hi = 0, tx_pulses = 0, tx_hi = 0;
  int         oe_cycles = 0, both_hi = 0;
  logic       rx_prev = 1'b0, tx_prev = 1'b0;
  logic [7:0] rx_log [0:255];

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_req(tx_req), .busy(busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_hi++;
      if (!rx_prev) begin
        rx_log[rx_pulses % 256] = rx_data;
        rx_pulses++;
      end
    end
    if (tx_req) begin
      tx_hi++;
      if (!tx_prev) tx_pulses++;
    end
    if (sda_oe) oe_cycles++;
    if (rx_valid && tx_req) both_hi++;
    rx_prev = rx_valid;
    tx_prev = tx_req;
  end

  // ---------------- bus model ----------------
  task automatic bus_start();
    if (!scl) begin
      sda_m = 1'b1; #QT; scl = 1'b1; #QT;
    end
    sda_m = 1'b0; #QT; scl = 1'b0; #QT;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #QT; scl = 1'b1; #QT; sda_m = 1'b1; #QT;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b; #QT; scl = 1'b1; #QT; s = sda_bus; #QT; scl = 1'b0; #QT;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(mack, s);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    vectors++; if (tx_req !== 1'b0) begin miscompares++; $display("FAIL reset_tx_req got=%b exp=0", tx_req); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] data [0:2];
    logic       ack;
    int         n, base;
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? 1 : 1 + int'($urandom_range(2));
      for (int i = 0; i < 3; i++) data[i] = 8'($urandom);
      if (it == 0) data[0] = 8'h3C;
      base = rx_pulses;
      bus_start();
      write_byte(8'hA0, ack);
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL write_addr_ack it=%0d got=%b exp=0", it, ack); end
      for (int i = 0; i < n; i++) begin
        write_byte(data[i], ack);
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL write_data_ack it=%0d byte=%0d got=%b exp=0", it, i, ack); end
      end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write_busy it=%0d got=%b exp=1", it, busy); end
      bus_stop();
      #QT;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL write_busy_after_stop it=%0d got=%b exp=0", it, busy); end
      vectors++; if (rx_pulses - base !== n) begin miscompares++; $display("FAIL write_rx_count it=%0d got=%0d exp=%0d", it, rx_pulses - base, n); end
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (rx_log[(base + i) % 256] !== data[i]) begin
          miscompares++; $display("FAIL write_rx_data it=%0d byte=%0d got=%h exp=%h", it, i, rx_log[(base + i) % 256], data[i]);
        end
      end
    end
    vectors++; if (rx_hi !== rx_pulses) begin miscompares++; $display("FAIL rx_valid_width got=%0d cycles exp=%0d", rx_hi, rx_pulses); end
    vectors++; if (both_hi !== 0) begin miscompares++; $display("FAIL rx_tx_overlap got=%0d exp=0", both_hi); end
  endtask

  task automatic test_mismatch();
    logic [6:0] a;
    logic       ack;
    int         oe0, rx0, tx0;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) a = 7'h52;
      else do a = 7'($urandom); while (a == 7'h50);
      oe0 = oe_cycles; rx0 = rx_pulses; tx0 = tx_pulses;
      bus_start();
      write_byte({a, (it == 0) ? 1'b0 : 1'($urandom)}, ack);
      vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL mismatch_addr_ack addr=%h got=%b exp=1", a, ack); end
      write_byte((it == 0) ? 8'h55 : 8'($urandom), ack);
      vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL mismatch_data_ack addr=%h got=%b exp=1", a, ack); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mismatch_busy addr=%h got=%b exp=0", a, busy); end
      bus_stop();
      #QT;
      vectors++;
      if (oe_cycles != oe0 || rx_pulses != rx0 || tx_pulses != tx0) begin
        miscompares++;
        $display("FAIL mismatch_quiet addr=%h oe=%0d rx=%0d tx=%0d exp=0/0/0", a, oe_cycles - oe0, rx_pulses - rx0, tx_pulses - tx0);
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] b [0:2];
    logic [7:0] d;
    logic       ack;
    int         n, tx0;
    for (int it = 0; it < 3; it++) begin
      n = (it == 0) ? 2 : 1 + int'($urandom_range(2));
      for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
      if (it == 0) begin b[0] = 8'h96; b[1] = 8'h0F; end
      tx0 = tx_pulses;
      tx_data = b[0];
      bus_start();
      write_byte(8'hA1, ack);
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL read_addr_ack it=%0d got=%b exp=0", it, ack); end
      for (int i = 0; i < n; i++) begin
        if (i + 1 < n) tx_data = b[i + 1];
        read_byte((i == n - 1) ? 1'b1 : 1'b0, d);
        vectors++; if (d !== b[i]) begin miscompares++; $display("FAIL read_data it=%0d byte=%0d got=%h exp=%h", it, i, d, b[i]); end
      end
      vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL read_oe_after_nack it=%0d got=%b exp=0", it, sda_oe); end
      vectors++; if (tx_pulses - tx0 !== n) begin miscompares++; $display("FAIL read_tx_req_count it=%0d got=%0d exp=%0d", it, tx_pulses - tx0, n); end
      bus_stop();
      #QT;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_after_stop it=%0d got=%b exp=0", it, busy); end
    end
    vectors++; if (tx_hi !== tx_pulses) begin miscompares++; $display("FAIL tx_req_width got=%0d cycles exp=%0d", tx_hi, tx_pulses); end
    vectors++; if (both_hi !== 0) begin miscompares++; $display("FAIL rx_tx_overlap got=%0d exp=0", both_hi); end
  endtask

  task automatic test_rstart();
    logic [7:0] r, d;
    logic       ack, s;
    int         rx0;
    rx0 = rx_pulses;
    r = 8'($urandom);
    bus_start();
    write_byte(8'hA0, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rstart_first_ack got=%b exp=0", ack); end
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s);
    tx_data = r;
    bus_start();
    write_byte(8'hA1, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rstart_read_ack got=%b exp=0", ack); end
    read_byte(1'b1, d);
    vectors++; if (d !== r) begin miscompares++; $display("FAIL rstart_read_data got=%h exp=%h", d, r); end
    bus_stop();
    #QT;
    vectors++; if (rx_pulses != rx0) begin miscompares++; $display("FAIL rstart_no_rx_valid got=%0d exp=0", rx_pulses - rx0); end
  endtask

  task automatic test_stop_mid_read();
    logic [7:0] r;
    logic       ack, s;
    r = 8'($urandom) | 8'h04;
    tx_data = r;
    bus_start();
    write_byte(8'hA1, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL stopmid_addr_ack got=%b exp=0", ack); end
    for (int i = 7; i > 2; i--) begin
      clock_bit(1'b1, s);
      vectors++; if (s !== r[i]) begin miscompares++; $display("FAIL stopmid_bit%0d got=%b exp=%b", i, s, r[i]); end
    end
    bus_stop();
    #QT;
    vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL stopmid_oe got=%b exp=0", sda_oe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stopmid_busy got=%b exp=0", busy); end
    bus_start();
    write_byte(8'hA0, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL stopmid_next_ack got=%b exp=0", ack); end
    write_byte(8'($urandom), ack);
    bus_stop();
    #QT;
  endtask

  task automatic test_reset_mid();
    logic ack;
    tx_data = 8'($urandom) & 8'h7F;
    bus_start();
    write_byte(8'hA1, ack);
    vectors++; if (sda_oe !== 1'b1) begin miscompares++; $display("FAIL rstmid_oe_before got=%b exp=1", sda_oe); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL rstmid_oe_async got=%b exp=0", sda_oe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
    vectors++; if (rx_valid !== 1'b0 || tx_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_pulses got=%b%b exp=00", rx_valid, tx_req); end
    #19;
    scl = 1'b1; sda_m = 1'b1;
    #QT;
    @(negedge clk);
    rst = 1'b1;
    #QT;
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_rstart();
    test_stop_mid_read();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder), the other end of the bus driven by our master-side SCL generator (i2c_fclk plus master FSM).
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, receives write bytes and supplies read bytes.
- Drives SDA open-drain through an output-enable.

Parameters:
- ADDR, 7'h50, target address compared against the first byte after START.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x SCL frequency.
- rst  in  1  asynchronous, active-low reset.
- scl_in  in  1  bus SCL (raw, asynchronous).
- sda_in  in  1  bus SDA (raw, asynchronous).
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- rx_data  out  8  last byte written by the master.
- rx_valid  out  1  one-clk pulse when rx_data updates.
- tx_data  in  8  byte to send on read; sampled in the clk cycle where tx_req=1.
- tx_req  out  1  one-clk pulse: tx_data is captured this cycle.
- busy  out  1  1 from address match until STOP/START.

Behaviour:
- Reset (asynchronous assert, immediate effect): sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, FSM=IDLE, bit counter=0.
- Input conditioning:
  - SYNC_STAGES synchroniser, then a previous-value register.
  - Edges are detected SYNC_STAGES+1 clk cycles after a pin change.
  - Requirement on the bus: SCL high/low times of at least 4 clk cycles.
- Bus conditions:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both are checked in every state and take priority over bit processing.
- Data sampling and driving:
  - Data is sampled on SCL rising edge.
  - sda_oe changes only on SCL falling edge; START/STOP are the exception and release it at once.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- IDLE: on START -> ADDR with bit count cleared.
- ADDR (shift MSB first, 8 bits):
  - On the 8th rise, compare shift[7:1] with ADDR.
  - Match: busy=1 -> ADDR_ACK. If R/W=1, tx_req pulses on that same cycle and tx_data loads the shift register.
  - Mismatch: -> IGNORE with sda_oe held 0.
- ADDR_ACK:
  - Next SCL fall: sda_oe=1.
  - 9th rise: count cleared.
  - Following fall: for R/W=0, sda_oe=0 -> WR_DATA; for R/W=1, sda_oe=~tx bit7 -> RD_DATA.
- WR_DATA:
  - Shift on each rise.
  - On the 8th rise: rx_data<=byte, rx_valid pulses 1 clk -> WR_ACK.
- WR_ACK: always ACK; sda_oe=1 from next fall to the fall after the 9th rise, then -> WR_DATA.
- RD_DATA:
  - On each fall, sda_oe = ~next bit, MSB first.
  - After the 8th bit's fall, sda_oe=0 -> RD_ACK.
- RD_ACK, sample SDA on the 9th rise:
  - 0 (ACK): tx_req pulses, tx_data loads, -> RD_DATA with bit7 driven on the next fall.
  - 1 (NACK): -> IGNORE.
- IGNORE: sda_oe=0; waits for START (-> ADDR) or STOP (-> IDLE).
- STOP in any state: -> IDLE, sda_oe=0, busy=0, partial byte discarded, no rx_valid.
- Repeated START in any state, including mid-byte: -> ADDR, count cleared, sda_oe=0, busy=0.
- rx_valid and tx_req are never high simultaneously; each is exactly one clk wide.
- Reset mid-transfer: sda_oe released asynchronously; the in-flight byte is lost.

Decomposition:
- Package i2c_pkg holds:
  - FSM state typedef/encoding.
  - I2C_ACK=0, I2C_NACK=1.
  - DEFAULT_ADDR=7'h50.
  - Byte width 8.
- Sub-module i2c_sync_edge (synchroniser plus rise/fall pulse outputs), instantiated once for SCL and once for SDA.

Test Plan:
- Write: START, 0xA0, 0x3C, STOP -> ACK (SDA low) on both 9th clocks; rx_data=0x3C with a single rx_valid pulse; busy returns to 0 after STOP.
- Address mismatch: START, 0xA4, 0x55 -> sda_oe stays 0 for the whole frame, no rx_valid/tx_req, busy=0.
- Read: START, 0xA1, tx_data=0x96, master ACK, tx_data=0x0F, master NACK, STOP -> SDA bits 1001_0110 then 0000_1111; tx_req pulses twice; sda_oe=0 after NACK.
- Repeated START after 4 bits of a write byte, then 0xA1 -> no rx_valid; address phase restarts and read proceeds with ACK.
- STOP after 5 bits of a read byte -> sda_oe drops at once; FSM=IDLE; next START+0xA0 is acknowledged.
- rst low during RD_DATA with sda_oe=1 -> sda_oe=0 in the same time step (before next clk edge); all outputs at reset values.
